// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALUOp, op-code and FSM encodings
// plus op_latency() for the alu_ctrl_seq stage.
package alu_ctrl_pkg;

    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_I   = 2'b11;

    localparam logic [4:0] OP_AND    = 5'b00000;
    localparam logic [4:0] OP_OR     = 5'b00001;
    localparam logic [4:0] OP_ADD    = 5'b00010;
    localparam logic [4:0] OP_XOR    = 5'b00011;
    localparam logic [4:0] OP_SRL    = 5'b00100;
    localparam logic [4:0] OP_SRA    = 5'b00101;
    localparam logic [4:0] OP_SUB    = 5'b00110;
    localparam logic [4:0] OP_SLT    = 5'b00111;
    localparam logic [4:0] OP_SLL    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    function automatic int op_latency(
        input logic [4:0] op,
        input int         mul_lat,
        input int         div_lat
    );
        if (op inside {[OP_MUL:OP_MULHU]})
            return mul_lat;
        else if (op inside {[OP_DIV:OP_REMU]})
            return div_lat;
        else
            return 1;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {alu_op, funct} ->
// {code, illegal, multi_cycle}; funct = {f7[5], f7[0], f3}.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  logic [1:0] alu_op,
    input  logic [4:0] funct,
    output logic [4:0] code,
    output logic       illegal,
    output logic       multi_cycle
);

    logic       f75;
    logic       f70;
    logic [2:0] f3;
    logic [4:0] op;
    logic       ill;
    logic       mc;

    assign f75 = funct[4];
    assign f70 = funct[3];
    assign f3  = funct[2:0];

    // I-type arithmetic map; shifts (101) are resolved by the caller.
    function automatic logic [4:0] imap(input logic [2:0] f);
        logic [4:0] r;
        unique case (f)
            3'b000:  r = OP_ADD;
            3'b001:  r = OP_SLL;
            3'b010:  r = OP_SLT;
            3'b011:  r = OP_SLTU;
            3'b100:  r = OP_XOR;
            3'b110:  r = OP_OR;
            3'b111:  r = OP_AND;
            default: r = OP_SRL;
        endcase
        return r;
    endfunction

    always_comb begin
        op  = OP_ADD;
        ill = 1'b0;
        mc  = 1'b0;
        unique case (alu_op)
            AOP_MEM: begin
                op = (f3 == 3'b001) ? OP_SLL : OP_ADD;
            end
            AOP_BR: begin
                op = OP_SUB;
            end
            AOP_I: begin
                if (f3 == 3'b101) begin
                    op = f75 ? OP_SRA : OP_SRL;
                end else begin
                    op  = imap(f3);
                    ill = f75;
                end
            end
            default: begin
                if (f70) begin
                    if (ENABLE_M != 0 && !f75) begin
                        op = {2'b10, f3};
                        mc = 1'b1;
                    end else begin
                        ill = 1'b1;
                    end
                end else if (f3 == 3'b000) begin
                    op = f75 ? OP_SUB : OP_ADD;
                end else if (f3 == 3'b101) begin
                    op = f75 ? OP_SRA : OP_SRL;
                end else begin
                    op  = imap(f3);
                    ill = f75;
                end
            end
        endcase
        // Undecodable requests fall back to a plain 1-cycle ADD.
        if (ill) begin
            op = OP_ADD;
            mc = 1'b0;
        end
    end

    assign code        = op;
    assign illegal     = ill;
    assign multi_cycle = mc;

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control stage, valid/ready in and out,
// holds MUL/DIV results for MUL_LAT/DIV_LAT cycles; flush kills.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W     = 5,
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [4:0]      funct,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] operation,
    output logic            multi_cycle,
    output logic            illegal,
    output logic            busy
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL) + 1;

    state_t        st;
    state_t        st_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          accept;
    logic          load;
    logic [4:0]    d_code;
    logic          d_ill;
    logic          d_mc;
    int            d_lat;

    alu_ctrl_decode #(
        .ENABLE_M(ENABLE_M)
    ) u_dec (
        .alu_op     (alu_op),
        .funct      (funct),
        .code       (d_code),
        .illegal    (d_ill),
        .multi_cycle(d_mc)
    );

    assign d_lat    = op_latency(d_code, MUL_LAT, DIV_LAT);
    assign in_ready = (st == ST_IDLE)
                    | ((st == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready & ~flush;
    assign out_valid = (st == ST_HOLD);
    assign busy      = (st == ST_WAIT);

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        load  = 1'b0;
        unique case (st)
            ST_IDLE: begin
                load = accept;
            end
            ST_WAIT: begin
                if (cnt == CW'(1)) begin
                    st_n  = ST_HOLD;
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (accept)
                    load = 1'b1;
                else if (out_ready)
                    st_n = ST_IDLE;
            end
            default: begin
                st_n  = ST_IDLE;
                cnt_n = '0;
            end
        endcase
        // Counter holds L-1 so HOLD is reached L cycles after accept.
        if (load) begin
            if (d_lat > 1) begin
                st_n  = ST_WAIT;
                cnt_n = CW'(d_lat - 1);
            end else begin
                st_n  = ST_HOLD;
                cnt_n = '0;
            end
        end
        if (flush) begin
            st_n  = ST_IDLE;
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= ST_IDLE;
            cnt         <= '0;
            operation   <= '0;
            multi_cycle <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
            if (load) begin
                operation   <= OP_W'(d_code);
                multi_cycle <= d_mc;
                illegal     <= d_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed table + sequences for alu_ctrl_seq,
// default instance plus an ENABLE_M=0 instance on shared inputs.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic       flush;
    logic [1:0] alu_op;
    logic [4:0] funct;

    logic       in_ready;
    logic       out_valid;
    logic [4:0] operation;
    logic       multi_cycle;
    logic       illegal;
    logic       busy;

    logic       z_in_ready;
    logic       z_out_valid;
    logic [4:0] z_operation;
    logic       z_multi_cycle;
    logic       z_illegal;
    logic       z_busy;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq #(
        .OP_W(5), .ENABLE_M(1), .MUL_LAT(3), .DIV_LAT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .operation(operation), .multi_cycle(multi_cycle),
        .illegal(illegal), .busy(busy)
    );

    alu_ctrl_seq #(
        .OP_W(5), .ENABLE_M(0), .MUL_LAT(3), .DIV_LAT(8)
    ) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(z_in_ready),
        .alu_op(alu_op), .funct(funct), .flush(flush),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .operation(z_operation), .multi_cycle(z_multi_cycle),
        .illegal(z_illegal), .busy(z_busy)
    );

    typedef struct {
        logic [1:0] aop;
        logic [4:0] fn;
        logic [4:0] op;
        logic       ill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [1:0] a, input logic [4:0] f,
        input logic [4:0] o, input logic i
    );
        vec_t v;
        v.aop = a; v.fn = f; v.op = o; v.ill = i;
        return v;
    endfunction

    task automatic chk(
        input string nm,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        flush = 1'b0; alu_op = 2'b00; funct = 5'b00000;

        tbl.push_back(mk(2'b10, 5'b00000, 5'b00010, 1'b0));
        tbl.push_back(mk(2'b10, 5'b10000, 5'b00110, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00101, 5'b00100, 1'b0));
        tbl.push_back(mk(2'b11, 5'b10101, 5'b00101, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00000, 5'b00010, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00001, 5'b01000, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00010, 5'b00111, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00011, 5'b01001, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00100, 5'b00011, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00110, 5'b00001, 1'b0));
        tbl.push_back(mk(2'b11, 5'b00111, 5'b00000, 1'b0));
        tbl.push_back(mk(2'b00, 5'b00001, 5'b01000, 1'b0));
        tbl.push_back(mk(2'b00, 5'b00010, 5'b00010, 1'b0));
        tbl.push_back(mk(2'b01, 5'b00000, 5'b00110, 1'b0));
        tbl.push_back(mk(2'b10, 5'b10001, 5'b00010, 1'b1));
        tbl.push_back(mk(2'b10, 5'b11000, 5'b00010, 1'b1));
        tbl.push_back(mk(2'b10, 5'b10111, 5'b00010, 1'b1));
        tbl.push_back(mk(2'b10, 5'b00111, 5'b00000, 1'b0));
        tbl.push_back(mk(2'b11, 5'b10000, 5'b00010, 1'b1));
        tbl.push_back(mk(2'b10, 5'b10101, 5'b00101, 1'b0));

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_op", operation, 0);
        chk("rst_mc", multi_cycle, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1'b0;

        // latency-1 ops back to back
        out_ready = 1'b1;
        in_valid  = 1'b1;
        foreach (tbl[i]) begin
            alu_op = tbl[i].aop;
            funct  = tbl[i].fn;
            @(negedge clk);
            chk($sformatf("v%0d_op", i), operation, tbl[i].op);
            chk($sformatf("v%0d_ill", i), illegal, tbl[i].ill);
            chk($sformatf("v%0d_mc", i), multi_cycle, 0);
            chk($sformatf("v%0d_val", i), out_valid, 1);
            chk($sformatf("v%0d_rdy", i), in_ready, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_idle", out_valid, 0);

        // DIV latency, held request ignored during WAIT
        out_ready = 1'b0;
        alu_op = 2'b10; funct = 5'b01100; in_valid = 1'b1;
        @(negedge clk);
        alu_op = 2'b10; funct = 5'b00000;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("div_busy%0d", c), busy, 1);
            chk($sformatf("div_nrdy%0d", c), in_ready, 0);
            chk($sformatf("div_nval%0d", c), out_valid, 0);
            @(negedge clk);
        end
        chk("div_val", out_valid, 1);
        chk("div_op", operation, 5'b10100);
        chk("div_mc", multi_cycle, 1);
        chk("div_busy0", busy, 0);
        chk("div_ill", illegal, 0);

        // HOLD stall
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold_val%0d", c), out_valid, 1);
            chk($sformatf("hold_op%0d", c), operation, 5'b10100);
            chk($sformatf("hold_rdy%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("hold_rdy_up", in_ready, 1);
        @(negedge clk);
        chk("b2b_op", operation, 5'b00010);
        chk("b2b_val", out_valid, 1);
        chk("b2b_mc", multi_cycle, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", out_valid, 0);

        // M ops with ENABLE_M=0 vs 1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        alu_op = 2'b10; funct = 5'b01000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("nom_val", z_out_valid, 1);
        chk("nom_op", z_operation, 5'b00010);
        chk("nom_ill", z_illegal, 1);
        chk("nom_mc", z_multi_cycle, 0);
        chk("mul_busy1", busy, 1);
        chk("mul_op", operation, 5'b10000);
        chk("mul_mc", multi_cycle, 1);
        @(negedge clk);
        chk("mul_busy2", busy, 1);
        chk("mul_nval2", out_valid, 0);
        @(negedge clk);
        chk("mul_val3", out_valid, 1);
        chk("mul_op3", operation, 5'b10000);
        @(negedge clk);
        chk("mul_idle", out_valid, 0);

        // flush mid-MUL with a new request pending
        alu_op = 2'b10; funct = 5'b01000; in_valid = 1'b1;
        @(negedge clk);
        funct = 5'b00100;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_val", out_valid, 0);
        chk("fl_busy", busy, 0);
        chk("fl_rdy", in_ready, 1);
        chk("fl_op", operation, 5'b10000);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_drop_val", out_valid, 0);
        chk("fl_drop_op", operation, 5'b10000);

        // flush in IDLE drops the request
        in_valid = 1'b1; funct = 5'b00100; flush = 1'b1;
        @(negedge clk);
        chk("fli_val", out_valid, 0);
        chk("fli_op", operation, 5'b10000);
        flush = 1'b0;
        @(negedge clk);
        chk("fli_acc_op", operation, 5'b00011);
        chk("fli_acc_val", out_valid, 1);
        in_valid = 1'b0;
        @(negedge clk);

        // reset mid-WAIT
        alu_op = 2'b10; funct = 5'b01100; in_valid = 1'b1;
        @(negedge clk);
        funct = 5'b00100;
        @(negedge clk);
        chk("rw_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rw_val", out_valid, 0);
        chk("rw_busy0", busy, 0);
        chk("rw_op", operation, 0);
        chk("rw_mc", multi_cycle, 0);
        chk("rw_ill", illegal, 0);
        chk("rw_rdy", in_ready, 1);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nbad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Registered, parametrised ALU control stage for the pipelined RV32 datapath, sitting between decode and execute. It decodes ALUOp plus funct bits into an ALU operation code. Compared with the combinational single-cycle decoder, it adds:
- full RV32I R/I arithmetic decode;
- optional M-extension decode;
- an illegal-op flag with a defined fallback;
- valid/ready handshakes;
- a latency counter that holds the result for multi-cycle MUL/DIV.

Parameters:
OP_W, 5, width of operation code (min 5)
ENABLE_M, 1, 1 = decode M-extension ops, 0 = flag them illegal
MUL_LAT, 3, cycles from accept to out_valid for MUL/MULH/MULHSU/MULHU (>=1)
DIV_LAT, 8, cycles from accept to out_valid for DIV/DIVU/REM/REMU (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  decode presents a request
in_ready  out  1  stage can accept (combinational)
alu_op  in  2  00 load/store/legacy, 01 branch, 10 R-type, 11 I-type arith
funct  in  5  {funct7[5], funct7[0], funct3}
flush  in  1  synchronous pipeline kill
out_valid  out  1  operation valid to execute
out_ready  in  1  execute consumes
operation  out  OP_W  ALU op code
multi_cycle  out  1  registered op is MUL/DIV class
illegal  out  1  registered op was an undecodable combination
busy  out  1  counting multi-cycle latency

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, operation=0, multi_cycle=0, illegal=0, busy=0, counter=0.
- Op codes (shared package):
  - AND 00000, OR 00001, ADD 00010, XOR 00011, SRL 00100, SRA 00101, SUB 00110, SLT 00111, SLL 01000, SLTU 01001.
  - MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
  - Low 4 bits of AND/OR/ADD/SUB/SLL keep the legacy 4-bit encoding.
- Decode, alu_op=00: f3=001 -> SLL; else ADD.
- Decode, alu_op=01: SUB.
- Decode, alu_op=11:
  - f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - f3 101 -> SRA if f7[5], else SRL.
  - f7[5]=1 with any f3 other than 101 -> illegal.
- Decode, alu_op=10, f7[0]=0:
  - f3 000 -> SUB if f7[5], else ADD.
  - f3 101 -> SRA if f7[5], else SRL.
  - Other f3 follow the I-type map; f7[5]=1 with those f3 -> illegal.
- Decode, alu_op=10, f7[0]=1:
  - With ENABLE_M: f3 selects MUL..REMU in code order (000 MUL ... 111 REMU).
  - f7[5]&f7[0] -> illegal.
  - f7[0]=1 with ENABLE_M=0 -> illegal.
- Illegal result: operation=ADD, illegal=1, multi_cycle=0, latency 1. No latches; every combination is defined.
- FSM states IDLE, WAIT, HOLD.
- in_ready = (IDLE) | (HOLD & out_ready). It is 0 in WAIT.
- Accept = in_valid & in_ready & ~flush. On accept, operation/multi_cycle/illegal register on the same edge.
  - Latency 1 (non-M op): next state HOLD.
  - Latency L>1: next state WAIT with counter=L-1 and busy=1.
- WAIT: counter decrements each cycle. At counter==1, next state HOLD and busy=0. out_valid rises exactly L cycles after the accept edge.
- HOLD: out_valid=1; operation is stable until transfer.
  - On out_ready with no new accept -> IDLE.
  - On out_ready with a simultaneous accept -> back-to-back load of the new op. There is no bubble for latency-1 ops.
- out_ready is ignored outside HOLD.
- flush: highest priority after reset. From any state, next state is IDLE, out_valid=0, busy=0, counter=0. A request presented in the same cycle is discarded. The operation register retains its value.
- reset asserted mid-WAIT aborts immediately to reset values.
- The counter width is clog2(max(MUL_LAT,DIV_LAT))+1. It does not wrap.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALUOp localparams;
  - op-code localparams;
  - FSM state encoding;
  - function op_latency(op) returning MUL_LAT, DIV_LAT or 1.
- Sub-module alu_ctrl_decode: purely combinational {alu_op, funct} -> {operation, illegal, multi_cycle}, parametrised by ENABLE_M.
- The top level holds the FSM, counter and output registers.

Test Plan:
1. Reset, then alu_op=10, funct=00_000, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, operation=00010, illegal=0. Then IDLE.
2. alu_op=11 with f3=101 for f7[5]=0/1 and each remaining f3, out_ready=1, back-to-back -> SRL/SRA and the I-type map one per cycle. in_ready stays 1, no bubbles. Also alu_op=00 f3=001 -> 01000 and f3=010 -> 00010.
3. alu_op=10, funct=01_100 (DIV), DIV_LAT=8 -> in_ready=0 and busy=1 for cycles 1-7; out_valid at cycle 8, operation=10100, multi_cycle=1. A request held during WAIT is not accepted.
4. Result in HOLD with out_ready=0 for 5 cycles -> out_valid and operation stable. in_ready=0 until out_ready=1.
5. Illegal ops: funct=11_000, funct=10_111, and ENABLE_M=0 with funct=01_000 -> operation=00010, illegal=1, out_valid after 1 cycle.
6. flush at cycle 3 of MUL (MUL_LAT=3) concurrent with a new in_valid -> next cycle IDLE, out_valid=0, busy=0, new request dropped. Repeat with reset instead of flush -> all outputs at reset values.
